mips_state_sequencer: RTL and testbench

- Multicycle state sequencer for the MIPS CPU. It generates the 3-bit state that drives the control-signal decoder.
- It advances the instruction through FETCH, DECODE, EXECUTE, MEMORY_ACCESS and WRITE_BACK. It stalls on the memory-bus waitrequest and on a busy multiply/divide unit.
- It halts when the PC reaches the halt address, and exports active, stall and retired-instruction status.

---
 rtl/mips_state_sequencer_if.sv | 30 +++
 rtl/mips_state_sequencer.sv | 122 ++++++++++++
 tb/tb_mips_state_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_state_sequencer_if.sv
// Sequencer bus: instruction fields and bus status in, FSM state and status counters out.
interface mips_state_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       func_code;
    logic [4:0]       rt_code;
    logic [31:0]      pc;
    logic             waitrequest;
    logic             muldiv_busy;
    logic [2:0]       state;
    logic             active;
    logic             stall;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;
    logic             timeout;

    // Datapath / memory side: supplies the IR fields and bus status.
    modport master (
        output opcode, func_code, rt_code, pc, waitrequest, muldiv_busy,
        input  state, active, stall, instr_done, instr_count, cycle_count, timeout
    );

    // Sequencer side.
    modport slave (
        input  opcode, func_code, rt_code, pc, waitrequest, muldiv_busy,
        output state, active, stall, instr_done, instr_count, cycle_count, timeout
    );
endinterface

// File: rtl/mips_state_sequencer.sv
// Multicycle MIPS state sequencer: FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK
// with bus and mul/div stalls, halt address detection, stall watchdog and
// retired-instruction / active-cycle counters.
module mips_state_sequencer #(
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int          CNT_W          = 32,
    parameter int          TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mips_state_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'b000,
        S_DECODE  = 3'b001,
        S_EXECUTE = 3'b010,
        S_MEM     = 3'b011,
        S_WB      = 3'b100,
        S_HALTED  = 3'b101
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             timeout_q, timeout_d;

    logic stall_c, done_c, live_c, wd_fire;
    logic is_load, is_store, is_mem, is_muldiv;

    // REGIMM needs no special sequencing, so rt_code is carried but not decoded.
    logic unused_rt;
    assign unused_rt = ^bus.rt_code;

    // Opcode classes that affect sequencing.
    always_comb begin
        is_load   = (bus.opcode[5:3] == 3'b100) && (bus.opcode != 6'b100111);
        is_store  = (bus.opcode == 6'b101000) || (bus.opcode == 6'b101001) ||
                    (bus.opcode == 6'b101011);
        is_mem    = is_load || is_store;
        is_muldiv = (bus.opcode == 6'b000000) && (bus.func_code[5:2] == 4'b0110);
    end

    // Next state, stall/done decode, watchdog and counter updates.
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        done_c  = 1'b0;
        live_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                live_c = 1'b1;
                // Halt address takes priority over a pending fetch.
                if (bus.pc == HALT_ADDR)   state_d = S_HALTED;
                else if (bus.waitrequest)  stall_c = 1'b1;
                else                       state_d = S_DECODE;
            end
            S_DECODE: begin
                live_c  = 1'b1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                live_c = 1'b1;
                if (is_muldiv && bus.muldiv_busy) stall_c = 1'b1;
                else                              state_d = S_MEM;
            end
            S_MEM: begin
                live_c = 1'b1;
                if (is_mem && bus.waitrequest) stall_c = 1'b1;
                else if (is_load)              state_d = S_WB;
                else begin
                    state_d = S_FETCH;
                    done_c  = 1'b1;
                end
            end
            S_WB: begin
                live_c  = 1'b1;
                state_d = S_FETCH;
                done_c  = 1'b1;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;  // 110/111: recover without counting
        endcase

        // Watchdog: fires on the stall cycle that brings the run to TIMEOUT_CYCLES.
        // It can only fire on a stall, so it never collides with instr_done.
        stall_cnt_d = stall_c ? stall_cnt_q + 32'd1 : 32'd0;
        wd_fire     = (TIMEOUT_CYCLES != 0) && stall_c &&
                      (stall_cnt_d == 32'(TIMEOUT_CYCLES));
        if (wd_fire) state_d = S_HALTED;
        timeout_d = timeout_q | wd_fire;

        instr_cnt_d = done_c ? instr_cnt_q + 1'b1 : instr_cnt_q;
        cycle_cnt_d = live_c ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            stall_cnt_q <= '0;
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Status pulses are suppressed while reset is asserted.
    assign bus.state       = state_q;
    assign bus.active      = (state_q != S_HALTED);
    assign bus.stall       = reset_n & stall_c;
    assign bus.instr_done  = reset_n & done_c;
    assign bus.instr_count = instr_cnt_q;
    assign bus.cycle_count = cycle_cnt_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_mips_state_sequencer.sv
// Directed bench: two sequencers (watchdog off / watchdog = 4) on shared stimulus.
module tb_mips_state_sequencer;
    localparam logic [2:0] FE = 3'b000, DE = 3'b001, EX = 3'b010,
                           ME = 3'b011, WB = 3'b100, HA = 3'b101;
    localparam logic [31:0] RUN_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode, func_code;
    logic [4:0]  rt_code;
    logic [31:0] pc;
    logic        waitrequest, muldiv_busy;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mips_state_sequencer_if #(.CNT_W(32)) bus0 ();
    mips_state_sequencer_if #(.CNT_W(32)) bus4 ();

    assign bus0.opcode = opcode;   assign bus4.opcode = opcode;
    assign bus0.func_code = func_code; assign bus4.func_code = func_code;
    assign bus0.rt_code = rt_code; assign bus4.rt_code = rt_code;
    assign bus0.pc = pc;           assign bus4.pc = pc;
    assign bus0.waitrequest = waitrequest; assign bus4.waitrequest = waitrequest;
    assign bus0.muldiv_busy = muldiv_busy; assign bus4.muldiv_busy = muldiv_busy;

    mips_state_sequencer #(.HALT_ADDR(32'h0), .CNT_W(32), .TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    mips_state_sequencer #(.HALT_ADDR(32'h0), .CNT_W(32), .TIMEOUT_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Apply bus status for one cycle, check dut0 before the edge, then advance.
    task automatic cyc(input string tag, input logic wr, input logic bz,
                       input logic [2:0] es, input logic est, input logic edn);
        waitrequest = wr; muldiv_busy = bz; #1;
        chk({tag, ".state"}, 32'(bus0.state), 32'(es));
        chk({tag, ".stall"}, 32'(bus0.stall), 32'(est));
        chk({tag, ".done"},  32'(bus0.instr_done), 32'(edn));
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; waitrequest = 1'b0; muldiv_busy = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; opcode = 6'd0; func_code = 6'b100001; rt_code = 5'd0;
        pc = RUN_PC; waitrequest = 1'b1; muldiv_busy = 1'b0;

        // Reset state, with waitrequest high to show stall is held low in reset.
        @(posedge clk); tick();
        chk("rst.state", 32'(bus0.state), 32'(FE));
        chk("rst.active", 32'(bus0.active), 32'd1);
        chk("rst.stall", 32'(bus0.stall), 32'd0);
        chk("rst.done", 32'(bus0.instr_done), 32'd0);
        chk("rst.icnt", bus0.instr_count, 32'd0);
        chk("rst.ccnt", bus0.cycle_count, 32'd0);
        chk("rst.tmo", 32'(bus4.timeout), 32'd0);

        // ADDU: 4 cycles, no stalls.
        do_reset();
        cyc("addu0", 0, 0, FE, 0, 0);
        cyc("addu1", 0, 0, DE, 0, 0);
        cyc("addu2", 0, 0, EX, 0, 0);
        cyc("addu3", 0, 0, ME, 0, 1);
        chk("addu.state", 32'(bus0.state), 32'(FE));
        chk("addu.icnt", bus0.instr_count, 32'd1);
        chk("addu.ccnt", bus0.cycle_count, 32'd4);

        // LW: 3 fetch waits, 2 memory waits, then write-back; 10 cycles total.
        do_reset();
        opcode = 6'b100011;
        for (int i = 0; i < 3; i++) cyc("lw.fw", 1, 0, FE, 1, 0);
        cyc("lw.f", 0, 0, FE, 0, 0);
        cyc("lw.d", 1, 0, DE, 0, 0);   // waitrequest ignored in DECODE
        cyc("lw.e", 0, 0, EX, 0, 0);
        for (int i = 0; i < 2; i++) cyc("lw.mw", 1, 0, ME, 1, 0);
        cyc("lw.m", 0, 0, ME, 0, 0);
        cyc("lw.wb", 0, 0, WB, 0, 1);
        chk("lw.state", 32'(bus0.state), 32'(FE));
        chk("lw.icnt", bus0.instr_count, 32'd1);
        chk("lw.ccnt", bus0.cycle_count, 32'd10);

        // DIV: mul/div busy 6 cycles holds EXECUTE for 7.
        do_reset();
        opcode = 6'd0; func_code = 6'b011010;
        cyc("div.f", 0, 0, FE, 0, 0);
        cyc("div.d", 0, 0, DE, 0, 0);
        for (int i = 0; i < 6; i++) cyc("div.eb", 0, 1, EX, 1, 0);
        cyc("div.e", 0, 0, EX, 0, 0);
        cyc("div.m", 0, 0, ME, 0, 1);
        chk("div.icnt", bus0.instr_count, 32'd1);
        chk("div.ccnt", bus0.cycle_count, 32'd10);
        chk("div.tmo", 32'(bus0.timeout), 32'd0);

        // Non-muldiv R-type ignores muldiv_busy.
        do_reset();
        func_code = 6'b100001;
        cyc("addb.f", 0, 1, FE, 0, 0);
        cyc("addb.d", 0, 1, DE, 0, 0);
        cyc("addb.e", 0, 1, EX, 0, 0);
        cyc("addb.m", 0, 1, ME, 0, 1);

        // Halt address in FETCH beats a pending waitrequest; counters freeze.
        do_reset();
        pc = 32'h0;
        cyc("halt.f", 1, 0, FE, 0, 0);
        chk("halt.state", 32'(bus0.state), 32'(HA));
        chk("halt.active", 32'(bus0.active), 32'd0);
        for (int i = 0; i < 10; i++) cyc("halt.hold", i[0], 0, HA, 0, 0);
        chk("halt.icnt", bus0.instr_count, 32'd0);
        chk("halt.ccnt", bus0.cycle_count, 32'd1);
        chk("halt.tmo", 32'(bus0.timeout), 32'd0);
        pc = RUN_PC;

        // Watchdog: 4 fetch stalls halt dut4 with timeout; dut0 keeps stalling.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            waitrequest = 1'b1; #1;
            chk("wd.state", 32'(bus4.state), 32'(FE));
            chk("wd.stall", 32'(bus4.stall), 32'd1);
            chk("wd.tmo0", 32'(bus4.timeout), 32'd0);
            tick();
        end
        chk("wd.halt", 32'(bus4.state), 32'(HA));
        chk("wd.tmo", 32'(bus4.timeout), 32'd1);
        chk("wd.active", 32'(bus4.active), 32'd0);
        chk("wd.ccnt", bus4.cycle_count, 32'd4);
        chk("wd.off.state", 32'(bus0.state), 32'(FE));
        chk("wd.off.tmo", 32'(bus0.timeout), 32'd0);
        tick();
        chk("wd.sticky", 32'(bus4.timeout), 32'd1);
        reset_n = 1'b0; tick();
        chk("wd.rst.state", 32'(bus4.state), 32'(FE));
        chk("wd.rst.tmo", 32'(bus4.timeout), 32'd0);
        reset_n = 1'b1;

        // SW: reset during memory stall kills the instruction.
        do_reset();
        opcode = 6'b101011;
        cyc("sw.f", 0, 0, FE, 0, 0);
        cyc("sw.d", 0, 0, DE, 0, 0);
        cyc("sw.e", 0, 0, EX, 0, 0);
        waitrequest = 1'b1; #1;
        chk("sw.mstall", 32'(bus0.stall), 32'd1);
        reset_n = 1'b0; #1;
        chk("sw.rst.done", 32'(bus0.instr_done), 32'd0);
        tick();
        chk("sw.rst.state", 32'(bus0.state), 32'(FE));
        chk("sw.rst.icnt", bus0.instr_count, 32'd0);
        chk("sw.rst.ccnt", bus0.cycle_count, 32'd0);
        reset_n = 1'b1;

        // Undefined opcode: non-memory path, waitrequest ignored in MEMORY_ACCESS.
        do_reset();
        opcode = 6'b111111;
        cyc("undef.f", 0, 0, FE, 0, 0);
        cyc("undef.d", 0, 0, DE, 0, 0);
        cyc("undef.e", 0, 0, EX, 0, 0);
        cyc("undef.m", 1, 0, ME, 0, 1);
        chk("undef.state", 32'(bus0.state), 32'(FE));
        chk("undef.icnt", bus0.instr_count, 32'd1);
        chk("undef.ccnt", bus0.cycle_count, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
